vend_ctrl: RTL and testbench

//  Vending-machine sequencer: accumulates coin credit, validates item selection against a price table,

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_change_sel.sv | 21 ++
 rtl/vend_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vend_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
// Coin codes, coin values and the item price table live here.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_t;

   localparam logic [1:0] COIN_5   = 2'b00;
   localparam logic [1:0] COIN_10  = 2'b01;
   localparam logic [1:0] COIN_25  = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   // Value in cents indexed by coin code; the invalid code is worth nothing.
   localparam int COIN_VAL [4] = '{5, 10, 25, 0};

   // Price in cents indexed by item number.
   localparam int PRICE [4] = '{25, 35, 50, 65};

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin picker: largest coin (25, 10, 5) not exceeding the credit.
// Purely combinational; credit is always a multiple of 5.
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          chg_coin
);

   always_comb begin
      chg_coin = COIN_5;
      if (credit >= CREDIT_W'(COIN_VAL[COIN_25])) begin
         chg_coin = COIN_25;
      end else if (credit >= CREDIT_W'(COIN_VAL[COIN_10])) begin
         chg_coin = COIN_10;
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: coin credit, item selection, dispense handshake, change return.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int MAX_CREDIT  = 100,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic [3:0]          item_empty,
  input  logic                disp_ack,
  input  logic                chg_ready,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          disp_item_q, disp_item_d;
  logic [1:0]          chg_coin_q, chg_coin_d;
  logic                disp_req_q, disp_req_d;
  logic                chg_valid_q, chg_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_nack_q, sel_nack_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [1:0]          greedy_coin;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // One extra bit so the MAX_CREDIT compare cannot wrap.
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(COIN_VAL[coin_type]);
  assign coin_ok  = (coin_type != COIN_BAD) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Change coin is chosen from the credit that will be visible next cycle.
  vend_change_sel #(
    .CREDIT_W (CREDIT_W)
  ) u_change_sel (
    .credit   (credit_d),
    .chg_coin (greedy_coin)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_item_d   = disp_item_q;
    coin_reject_d = 1'b0;
    sel_nack_d    = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (state_q == ST_CREDIT)) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_valid;
          sel_nack_d    = sel_valid;
        end else if (coin_valid) begin
          sel_nack_d = sel_valid;
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (sel_valid) begin
          if ((state_q == ST_CREDIT) &&
              (credit_q >= CREDIT_W'(PRICE[sel_item])) &&
              !item_empty[sel_item]) begin
            state_d     = ST_DISPENSE;
            disp_item_d = sel_item;
          end else begin
            sel_nack_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        if (disp_ack) begin
          credit_d = credit_q - CREDIT_W'(PRICE[disp_item_q]);
          state_d  = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        sel_nack_d    = sel_valid;
        if (chg_valid_q && chg_ready) begin
          credit_d = credit_q - CREDIT_W'(COIN_VAL[chg_coin_q]);
          if (credit_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef VEND_TIMEOUT_EN
    // A rejected coin is not activity: it neither clears the count nor blocks the refund.
    if (state_q == ST_CREDIT) begin
      if ((coin_valid && coin_ok) || sel_valid) begin
        tmo_d = '0;
      end else if (state_d == ST_CREDIT) begin
        if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_CHANGE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end else if (state_d == ST_CREDIT) begin
      tmo_d = '0;
    end
`endif
  end

  always_comb begin
    disp_req_d  = (state_d == ST_DISPENSE);
    chg_valid_d = (state_d == ST_CHANGE);
    busy_d      = disp_req_d || chg_valid_d;
    chg_coin_d  = chg_valid_d ? greedy_coin : COIN_5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      disp_item_q   <= '0;
      chg_coin_q    <= '0;
      disp_req_q    <= 1'b0;
      chg_valid_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_nack_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_item_q   <= disp_item_d;
      chg_coin_q    <= chg_coin_d;
      disp_req_q    <= disp_req_d;
      chg_valid_q   <= chg_valid_d;
      coin_reject_q <= coin_reject_d;
      sel_nack_q    <= sel_nack_d;
      busy_q        <= busy_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign disp_req    = disp_req_q;
  assign disp_item   = disp_item_q;
  assign chg_valid   = chg_valid_q;
  assign chg_coin    = chg_coin_q;
  assign coin_reject = coin_reject_q;
  assign sel_nack    = sel_nack_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scenarios followed by random traffic, checked against a cents-level model
// of the machine (credit, vending/refunding flags) kept in this file.
module tb_vend_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic [3:0] item_empty;
  logic       disp_ack;
  logic       chg_ready;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       coin_reject;
  logic       sel_nack;
  logic [7:0] credit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_credit;
  bit m_vend;
  bit m_refund;
  int m_item;
  int m_coin;
  int m_tmo;
  bit e_rej;
  bit e_nack;

  always #5 clk = ~clk;

  vend_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .item_empty  (item_empty),
    .disp_ack    (disp_ack),
    .chg_ready   (chg_ready),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .coin_reject (coin_reject),
    .sel_nack    (sel_nack),
    .credit      (credit),
    .busy        (busy)
  );

  function automatic int coin_cents(int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(int item);
    case (item)
      0: return 25;
      1: return 35;
      2: return 50;
      default: return 65;
    endcase
  endfunction

  function automatic int greedy_code(int cents);
    if (cents >= 25) return 2;
    if (cents >= 10) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_credit"},    credit,      m_credit);
    chk({tag, "_disp_req"},  disp_req,    m_vend);
    chk({tag, "_disp_item"}, disp_item,   m_item);
    chk({tag, "_chg_valid"}, chg_valid,   m_refund);
    chk({tag, "_chg_coin"},  chg_coin,    m_coin);
    chk({tag, "_reject"},    coin_reject, e_rej);
    chk({tag, "_nack"},      sel_nack,    e_nack);
    chk({tag, "_busy"},      busy,        m_vend || m_refund);
  endtask

  task automatic model_reset();
    m_credit = 0; m_vend = 0; m_refund = 0; m_item = 0;
    m_coin = 0; m_tmo = 0; e_rej = 0; e_nack = 0;
  endtask

  task automatic model_step();
    int v;
    bit was_credit;
    e_rej = 0;
    e_nack = 0;
    was_credit = !m_vend && !m_refund && (m_credit > 0);
    if (m_vend) begin
      e_rej = coin_valid; e_nack = sel_valid;
      if (disp_ack) begin
        m_credit -= price_of(m_item);
        m_vend = 0;
        m_refund = (m_credit > 0);
      end
    end else if (m_refund) begin
      e_rej = coin_valid; e_nack = sel_valid;
      if (chg_ready) begin
        m_credit -= coin_cents(m_coin);
        if (m_credit == 0) m_refund = 0;
      end
    end else if (cancel && m_credit > 0) begin
      m_refund = 1; e_rej = coin_valid; e_nack = sel_valid;
    end else if (coin_valid) begin
      e_nack = sel_valid;
      v = coin_cents(coin_type);
      if (coin_type != 2'b11 && m_credit + v <= 100) m_credit += v;
      else e_rej = 1;
    end else if (sel_valid) begin
      if (m_credit > 0 && m_credit >= price_of(sel_item) && !item_empty[sel_item]) begin
        m_vend = 1; m_item = sel_item;
      end else begin
        e_nack = 1;
      end
    end
`ifdef VEND_TIMEOUT_EN
    if (!m_vend && !m_refund && m_credit > 0) begin
      if (!was_credit) m_tmo = 0;
      else if ((coin_valid && !e_rej) || sel_valid) m_tmo = 0;
      else if (m_tmo == TMO - 1) m_refund = 1;
      else m_tmo++;
    end
`endif
    m_coin = m_refund ? greedy_code(m_credit) : 0;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    coin_valid = 0; sel_valid = 0; cancel = 0; disp_ack = 0;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1; coin_type = t;
    cycle("coin");
  endtask

  task automatic select(input logic [1:0] i);
    sel_valid = 1; sel_item = i;
    cycle("sel");
  endtask

  task automatic do_cancel();
    cancel = 1;
    cycle("cancel");
  endtask

  task automatic ack();
    disp_ack = 1;
    cycle("ack");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    rst = 1; coin_valid = 0; coin_type = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; item_empty = 0; disp_ack = 0; chg_ready = 1;
    @(posedge clk);
    #1;
    do_reset();

    // 25c + 10c, buy item 1 exactly
    put_coin(2); put_coin(1);
    select(1);
    chk("t1_req", disp_req, 1);
    chk("t1_item", disp_item, 1);
    idle(2);
    ack();
    chk("t1_credit", credit, 0);
    chk("t1_no_change", chg_valid, 0);

    // 75c, buy item 2, one 25c back
    put_coin(2); put_coin(2); put_coin(2);
    select(2);
    ack();
    chk("t2_chg_valid", chg_valid, 1);
    chk("t2_chg_coin", chg_coin, 2);
    idle(1);
    chk("t2_done", chg_valid, 0);

    // insufficient credit, then cancel refunds 10c
    put_coin(1);
    select(0);
    chk("t3_nack", sel_nack, 1);
    chk("t3_credit", credit, 10);
    do_cancel();
    chk("t3_chg_coin", chg_coin, 1);
    idle(1);
    chk("t3_credit0", credit, 0);

    // MAX_CREDIT boundary, invalid coin, coin while dispensing
    put_coin(2); put_coin(2); put_coin(2); put_coin(1); put_coin(1);
    put_coin(1);
    chk("t4_over_rej", coin_reject, 1);
    chk("t4_credit95", credit, 95);
    put_coin(3);
    chk("t4_bad_rej", coin_reject, 1);
    put_coin(0);
    chk("t4_credit100", credit, 100);
    select(3);
    put_coin(0);
    chk("t4_disp_rej", coin_reject, 1);
    ack();
    idle(3);

    // sold-out item is refused
    item_empty = 4'b0010;
    put_coin(2); put_coin(1);
    select(1);
    chk("sold_out_nack", sel_nack, 1);
    item_empty = 4'b0000;
    do_cancel();
    idle(3);

    // cancel, coin and select in one cycle with 30c
    put_coin(2); put_coin(0);
    cancel = 1; coin_valid = 1; coin_type = 0; sel_valid = 1; sel_item = 0;
    cycle("t5");
    chk("t5_rej", coin_reject, 1);
    chk("t5_nack", sel_nack, 1);
    chk("t5_coin25", chg_coin, 2);
    idle(1);
    chk("t5_coin5", chg_coin, 0);
    chk("t5_credit5", credit, 5);
    idle(1);

    // reset while change is stalled
    chg_ready = 0;
    put_coin(2);
    do_cancel();
    idle(2);
    chk("rst_pre_chg", chg_valid, 1);
    do_reset();
    chg_ready = 1;

`ifdef VEND_TIMEOUT_EN
    put_coin(0);
    idle(TMO);
    chk("tmo_chg_valid", chg_valid, 1);
    chk("tmo_coin", chg_coin, 0);
    idle(1);
    chk("tmo_credit0", credit, 0);
`endif

    for (int i = 0; i < 800; i++) begin
      coin_valid = ($urandom_range(0, 3) == 0);
      coin_type  = 2'($urandom_range(0, 3));
      sel_valid  = ($urandom_range(0, 5) == 0);
      sel_item   = 2'($urandom_range(0, 3));
      cancel     = ($urandom_range(0, 19) == 0);
      disp_ack   = ($urandom_range(0, 2) == 0);
      chg_ready  = ($urandom_range(0, 1) == 1);
      item_empty = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
